// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit CPU: fetches two-byte instructions,
// drives ALU select/operand, strobes the accumulator and keeps pc and the zero flag.
module cpu_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] mem_addr,
    output logic       mem_req,
    input  logic [7:0] mem_rdata,
    input  logic       mem_valid,
    output logic [2:0] alu_sel,
    output logic [7:0] alu_b,
    input  logic       alu_z,
    output logic       acc_we,
    output logic       zf,
    output logic [7:0] pc,
    output logic       halted
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_OPD = 2'd1,
        EXEC      = 2'd2,
        HALT      = 2'd3
    } state_t;

    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t     state;
    logic [2:0] op;
    logic [7:0] opd;
    logic       req_q;
    logic       we_q;
    logic       halt_q;

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= FETCH_OP;
            pc     <= 8'h00;
            op     <= 3'b000;
            opd    <= 8'h00;
            zf     <= 1'b0;
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            case (state)
                FETCH_OP: begin
                    if (mem_valid) begin
                        op <= mem_rdata[7:5];
                        pc <= pc + 8'd1;
                        if (mem_rdata[7:5] == OP_HLT) begin
                            state  <= HALT;
                            req_q  <= 1'b0;
                            halt_q <= 1'b1;
                        end else begin
                            state <= FETCH_OPD;
                        end
                    end
                end
                FETCH_OPD: begin
                    if (mem_valid) begin
                        opd   <= mem_rdata;
                        pc    <= pc + 8'd1;
                        state <= EXEC;
                        req_q <= 1'b0;
                        we_q  <= (op < OP_JMP);
                    end
                end
                EXEC: begin
                    state <= FETCH_OP;
                    req_q <= 1'b1;
                    we_q  <= 1'b0;
                    if (we_q) begin
                        zf <= alu_z;
                    end else if (op == OP_JMP || (op == OP_JZ && zf)) begin
                        pc <= opd;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH_OP;
                end
            endcase
        end
    end

    // Reset is synchronous, so the strobes are also masked combinationally while rst_n is low.
    assign mem_addr = pc;
    assign mem_req  = req_q & rst_n;
    assign acc_we   = we_q & rst_n;
    assign halted   = halt_q & rst_n;
    assign alu_sel  = rst_n ? op  : 3'b000;
    assign alu_b    = rst_n ? opd : 8'h00;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: an instruction-level model predicts fetch
// addresses and execute events; a memory responder inserts wait states.
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_valid = 1'b0;
    logic [2:0] alu_sel;
    logic [7:0] alu_b;
    logic       alu_z;
    logic       acc_we;
    logic       zf;
    logic [7:0] pc;
    logic       halted;

    cpu_control_unit dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .alu_sel(alu_sel), .alu_b(alu_b),
        .alu_z(alu_z), .acc_we(acc_we), .zf(zf), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] b;
        logic [7:0] pc;
        logic       z;
    } ev_t;

    logic [7:0] mem [256];
    logic [7:0] exp_fetch [$];
    ev_t        exp_exec [$];
    logic [7:0] isa_pc, isa_acc;
    logic       isa_zf, isa_halts;
    int         isa_bound;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_fn(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            3'd0:    return b;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            default: return b;
        endcase
    endfunction

    // External ALU and accumulator.
    assign alu_z = (alu_fn(alu_sel, acc, alu_b) == 8'h00);
    always @(posedge clk) begin
        if (!rst_n) acc <= 8'h00;
        else if (acc_we) acc <= alu_fn(alu_sel, acc, alu_b);
    end

    // Instruction-level model: walks the program and records what the sequencer must do.
    task automatic build_model(input int w);
        logic [7:0] p, a, b, pc_x;
        logic       z;
        logic [2:0] o;
        exp_fetch.delete();
        exp_exec.delete();
        p = 8'h00; a = 8'h00; z = 1'b0;
        isa_halts = 1'b0;
        isa_bound = 0;
        for (int n = 0; n < 200; n++) begin
            exp_fetch.push_back(p);
            o = mem[p][7:5];
            p = p + 8'd1;
            if (o == 3'b111) begin
                isa_halts = 1'b1;
                isa_bound += 1 + w;
                break;
            end
            exp_fetch.push_back(p);
            b = mem[p];
            p = p + 8'd1;
            pc_x = p;
            isa_bound += 3 + 2 * w;
            if (o <= 3'd4) begin
                a = alu_fn(o, a, b);
                z = (a == 8'h00);
            end else if (o == 3'b101 || (o == 3'b110 && z)) begin
                p = b;
            end
            exp_exec.push_back('{op: o, b: b, pc: pc_x, z: z});
        end
        isa_pc = p; isa_acc = a; isa_zf = z;
    endtask

    // Monitor + memory responder state.
    bit         mon_en = 1'b0;
    int         cyc = 0;
    logic       req_d = 1'b0, valid_d = 1'b0;
    logic [7:0] addr_d = 8'h00, rdata_d = 8'h00;
    logic       opd_phase = 1'b0, halt_seen = 1'b0, exec_now, zf_pending = 1'b0, zf_exp = 1'b0;
    logic [2:0] cur_op = 3'b000;
    int         halt_cyc = 0;
    int         n_we = 0;
    int         we_cyc [8];
    logic [7:0] addr_log [64];
    int         wcnt = 0, cur_w = 0, max_w = 0;
    bit         rnd_w = 1'b0;
    ev_t        ev;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (cyc < 64) addr_log[cyc] = mem_addr;
            exec_now = 1'b0;
            if (req_d && valid_d) begin
                if (exp_fetch.size() == 0) check("fetch_unexpected", 1, 0);
                else check("fetch_addr", addr_d, exp_fetch.pop_front());
                if (!opd_phase) begin
                    cur_op = rdata_d[7:5];
                    if (cur_op == 3'b111) begin
                        halt_seen = 1'b1;
                        halt_cyc  = cyc;
                    end else begin
                        opd_phase = 1'b1;
                    end
                end else begin
                    opd_phase = 1'b0;
                    exec_now  = 1'b1;
                end
            end
            if (zf_pending) begin
                check("zf", zf, zf_exp);
                zf_pending = 1'b0;
            end
            check("acc_we", acc_we, exec_now && cur_op <= 3'd4);
            check("mem_req", mem_req, !exec_now && !halt_seen);
            check("halted", halted, halt_seen);
            if (exec_now) begin
                if (exp_exec.size() == 0) begin
                    check("exec_unexpected", 1, 0);
                end else begin
                    ev = exp_exec.pop_front();
                    check("alu_sel", alu_sel, ev.op);
                    check("alu_b", alu_b, ev.b);
                    check("exec_pc", pc, ev.pc);
                    if (ev.op <= 3'd4) begin
                        zf_pending = 1'b1;
                        zf_exp     = ev.z;
                        if (n_we < 8) we_cyc[n_we] = cyc;
                        n_we++;
                    end
                end
            end
        end
        // Drive the response for the coming edge; junk valid/data whenever no request is open.
        if (mem_req) begin
            if (wcnt >= cur_w) begin
                mem_valid = 1'b1;
                mem_rdata = mem[mem_addr];
                wcnt      = 0;
                cur_w     = rnd_w ? $urandom_range(max_w, 0) : max_w;
            end else begin
                mem_valid = 1'b0;
                mem_rdata = 8'($urandom);
                wcnt++;
            end
        end else begin
            mem_valid = 1'($urandom);
            mem_rdata = 8'($urandom);
        end
        req_d = mem_req; valid_d = mem_valid; addr_d = mem_addr; rdata_d = mem_rdata;
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; mon_en = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        wcnt = 0; cur_w = rnd_w ? $urandom_range(max_w, 0) : max_w;
        req_d = 1'b0; valid_d = 1'b0; cyc = 0; opd_phase = 1'b0; halt_seen = 1'b0;
        zf_pending = 1'b0; n_we = 0; halt_cyc = 0;
        rst_n = 1'b1; mon_en = 1'b1;
    endtask

    // Reset asserted for one edge while the sequencer is mid-instruction.
    task automatic mid_reset();
        rst_n = 1'b0; mon_en = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_acc_we", acc_we, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_halted", halted, 0);
        @(posedge clk); #1;
        check("rst_pc", pc, 0);
        check("rst_zf", zf, 0);
        check("rst_we_count", n_we, 1);
        #1 rst_n = 1'b1;
        #1;
        check("rel_mem_req", mem_req, 1);
        check("rel_mem_addr", mem_addr, 0);
    endtask

    task automatic run(input int w, input bit rnd, input int limit, input int abort_c);
        int lim;
        max_w = w; rnd_w = rnd;
        build_model(w);
        lim = isa_halts ? isa_bound + 10 : limit;
        do_reset();
        forever begin
            @(posedge clk); #2;
            if (abort_c != 0 && cyc + 1 == abort_c) begin
                mid_reset();
                return;
            end
            if (halt_seen && cyc >= halt_cyc + 3) break;
            if (cyc >= lim) begin
                if (isa_halts) check("halt_timeout", 0, 1);
                break;
            end
        end
        mon_en = 1'b0;
        if (isa_halts) begin
            check("end_halted", halted, 1);
            check("end_pc", pc, isa_pc);
            check("end_acc", acc, isa_acc);
            check("end_zf", zf, isa_zf);
            check("fetch_left", exp_fetch.size(), 0);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // LDI 05, ADD 03, HLT: pulses in cycles 3 and 6, HALT seen after the seventh edge.
        fill(8'hFF);
        mem[0] = 8'h00; mem[1] = 8'h05; mem[2] = 8'h20; mem[3] = 8'h03;
        run(0, 1'b0, 100, 0);
        check("t1_we0_cyc", we_cyc[0], 3);
        check("t1_we1_cyc", we_cyc[1], 6);
        check("t1_halt_cyc", halt_cyc, 8);
        check("t1_acc", acc, 8'h08);

        // SUB to zero, JZ taken to 0x09 holding HLT.
        fill(8'hFF);
        mem[0] = 8'h00; mem[1] = 8'h04; mem[2] = 8'h40; mem[3] = 8'h04;
        mem[4] = 8'hC0; mem[5] = 8'h09; mem[6] = 8'h00; mem[7] = 8'h77;
        run(0, 1'b0, 100, 0);
        check("t2_pc", pc, 8'h0A);
        check("t2_zf", zf, 1);

        // JZ not taken: target 0x20 is never fetched.
        fill(8'hFF);
        mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'hC0; mem[3] = 8'h20;
        mem[8'h20] = 8'h00;
        run(0, 1'b0, 100, 0);
        check("t3_pc", pc, 8'h05);

        // Two wait cycles on every fetch.
        fill(8'hFF);
        mem[0] = 8'h00; mem[1] = 8'hAA;
        run(2, 1'b0, 100, 0);
        for (int c = 1; c <= 6; c++) check("t4_addr_hold", addr_log[c], (c <= 3) ? 0 : 1);
        check("t4_we_cyc", we_cyc[0], 7);
        check("t4_we_count", n_we, 1);
        check("t4_halt_cyc", halt_cyc, 11);

        // JMP FF, LDI at 0xFF whose operand wraps to 0x00.
        fill(8'hFF);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hA0; mem[3] = 8'hFF;
        mem[8'hFF] = 8'h00;
        run(0, 1'b0, 100, 0);
        check("t5_we_count", n_we, 3);

        // Reset during FETCH_OPD of an ADD, then a clean rerun.
        fill(8'hFF);
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h20; mem[3] = 8'h03;
        run(0, 1'b0, 100, 5);
        run(0, 1'b0, 100, 0);

        // Random programs with random wait states.
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            run(2, 1'b1, 300, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
